// File: rtl/uart_rx_frame_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame_ctrl_if
//  Purpose  : Bundles every uart_rx_frame_ctrl signal except clk/rst.
//             in_*    : byte stream from uart_rx (valid/ready)
//             out_*   : checked payload stream to the command logic
//             frame_ok/frame_err/err_code/busy : frame status
//  Modports : master - environment side (uart_rx and the downstream sink)
//             slave  - frame controller side
//  Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_frame_ctrl_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_last;
   logic       out_ready;
   logic       frame_ok;
   logic       frame_err;
   logic [1:0] err_code;
   logic       busy;

   modport master (
      output in_data, in_valid, out_ready,
      input  in_ready, out_data, out_valid, out_last,
             frame_ok, frame_err, err_code, busy
   );

   modport slave (
      input  in_data, in_valid, out_ready,
      output in_ready, out_data, out_valid, out_last,
             frame_ok, frame_err, err_code, busy
   );
endinterface
`default_nettype wire

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx_frame_ctrl
//  Purpose  : Parses SYNC, LEN, payload, CSUM frames from the uart_rx byte
//             stream, buffers the payload and releases it only after the
//             8-bit checksum (LEN plus all payload bytes, mod 256) matches.
//  Ports    : clk - system clock
//             rst - synchronous reset, active-high
//             bus - uart_rx_frame_ctrl_if.slave (input stream, output
//                   stream, frame_ok/frame_err pulses, err_code, busy)
//  Options  : RX_FRAME_TIMEOUT_EN - when defined, an inter-byte timeout of
//             TIMEOUT_CYC cycles aborts a frame in LEN/PAYLOAD/CSUM.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx_frame_ctrl #(
   parameter logic [7:0] SYNC    = 8'hA5,
   parameter int         MAX_LEN = 16
`ifdef RX_FRAME_TIMEOUT_EN
   ,
   parameter int         TIMEOUT_CYC = 8680
`endif
) (
   input  wire logic           clk,
   input  wire logic           rst,
   uart_rx_frame_ctrl_if.slave bus
);

   localparam int         PW        = $clog2(MAX_LEN + 1);
   // Buffer address width; pointers never exceed MAX_LEN-1 when used as addresses
   localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_LEN     = 3'd1,
      S_PAYLOAD = 3'd2,
      S_CSUM    = 3'd3,
      S_DRAIN   = 3'd4
   } state_t;

   state_t          state, state_nx;
   logic [7:0]      mem [MAX_LEN];
   logic [PW-1:0]   wr_ptr, rd_ptr;
   logic [7:0]      len, sum;
   logic            frame_ok_r, frame_err_r;
   logic [1:0]      err_code_r;
   logic            ok_nx, err_nx;
   logic [1:0]      code_nx;
   logic            in_ready_c, accept, xfer, last_rd;
   logic            timeout_hit;

   assign in_ready_c = !rst && (state != S_DRAIN);
   assign accept     = bus.in_valid && in_ready_c;
   assign xfer       = (state == S_DRAIN) && bus.out_ready;
   assign last_rd    = (8'(rd_ptr) == (len - 8'd1));

`ifdef RX_FRAME_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYC + 1);
   logic [TW-1:0] to_cnt;
   logic          to_run;

   assign to_run      = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CSUM);
   // A byte arriving on the expiry cycle wins over the timeout
   assign timeout_hit = to_run && !accept && (to_cnt == TW'(TIMEOUT_CYC - 1));

   always_ff @(posedge clk) begin
      if (rst || accept || !to_run)
         to_cnt <= '0;
      else
         to_cnt <= to_cnt + TW'(1);
   end
`else
   assign timeout_hit = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= S_HUNT;
      else
         state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      ok_nx    = 1'b0;
      err_nx   = 1'b0;
      code_nx  = err_code_r;
      case (state)
         S_HUNT: begin
            if (accept && (bus.in_data == SYNC))
               state_nx = S_LEN;
         end
         S_LEN: begin
            if (accept) begin
               if (bus.in_data > MAX_LEN_B) begin
                  state_nx = S_HUNT;
                  err_nx   = 1'b1;
                  code_nx  = 2'b01;
               end else if (bus.in_data == 8'd0) begin
                  state_nx = S_CSUM;
               end else begin
                  state_nx = S_PAYLOAD;
               end
            end
         end
         S_PAYLOAD: begin
            if (accept && ((8'(wr_ptr) + 8'd1) == len))
               state_nx = S_CSUM;
         end
         S_CSUM: begin
            if (accept) begin
               if (bus.in_data == sum) begin
                  ok_nx    = 1'b1;
                  state_nx = (len == 8'd0) ? S_HUNT : S_DRAIN;
               end else begin
                  err_nx   = 1'b1;
                  code_nx  = 2'b10;
                  state_nx = S_HUNT;
               end
            end
         end
         S_DRAIN: begin
            if (xfer && last_rd)
               state_nx = S_HUNT;
         end
         default: state_nx = S_HUNT;
      endcase
      if (timeout_hit) begin
         state_nx = S_HUNT;
         err_nx   = 1'b1;
         code_nx  = 2'b11;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         frame_ok_r  <= 1'b0;
         frame_err_r <= 1'b0;
         err_code_r  <= 2'b00;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         len         <= 8'd0;
         sum         <= 8'd0;
      end else begin
         frame_ok_r  <= ok_nx;
         frame_err_r <= err_nx;
         err_code_r  <= code_nx;
         if ((state == S_HUNT) && (state_nx == S_LEN)) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end
         if ((state == S_LEN) && accept) begin
            len <= bus.in_data;
            sum <= bus.in_data;
         end
         if ((state == S_PAYLOAD) && accept) begin
            wr_ptr <= wr_ptr + PW'(1);
            sum    <= sum + bus.in_data;
         end
         if (xfer)
            rd_ptr <= rd_ptr + PW'(1);
      end
   end

   // Payload storage carries no reset; it is only read back in DRAIN
   always_ff @(posedge clk) begin
      if ((state == S_PAYLOAD) && accept)
         mem[wr_ptr[AW-1:0]] <= bus.in_data;
   end

   assign bus.in_ready  = in_ready_c;
   assign bus.out_valid = (state == S_DRAIN);
   assign bus.out_data  = (state == S_DRAIN) ? mem[rd_ptr[AW-1:0]] : 8'd0;
   assign bus.out_last  = (state == S_DRAIN) && last_rd;
   assign bus.frame_ok  = frame_ok_r;
   assign bus.frame_err = frame_err_r;
   assign bus.err_code  = err_code_r;
   assign bus.busy      = (state != S_HUNT);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx_frame_ctrl
//  Purpose  : Scoreboard bench for uart_rx_frame_ctrl. Expected payload bytes
//             and frame results are queued as frames are driven and compared
//             when the controller emits them.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_frame_ctrl;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   logic [8:0] out_q[$];   // {last, data}
   logic [2:0] ev_q[$];    // {is_err, err_code}
   logic [1:0] exp_code = 2'b00;
   bq_t        pl;

   always #5 clk = ~clk;

   uart_rx_frame_ctrl_if bus ();

   uart_rx_frame_ctrl #(
      .SYNC    (8'hA5),
      .MAX_LEN (16)
`ifdef RX_FRAME_TIMEOUT_EN
      ,
      .TIMEOUT_CYC (100)
`endif
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard side: compare everything the controller produces
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.out_valid && bus.out_ready) begin
            if (out_q.size() == 0)
               chk("unexpected_out", {23'd0, bus.out_last, bus.out_data}, 32'h1ff);
            else
               chk("out_byte", {23'd0, bus.out_last, bus.out_data}, {23'd0, out_q.pop_front()});
         end
         if (bus.frame_ok || bus.frame_err) begin
            if (bus.frame_ok && bus.frame_err)
               chk("ok_err_overlap", 1, 0);
            if (ev_q.size() == 0)
               chk("unexpected_event", {29'd0, bus.frame_err, bus.err_code}, 32'h7);
            else
               chk("frame_event", {29'd0, bus.frame_err, bus.err_code}, {29'd0, ev_q.pop_front()});
         end
      end
   end

   // Drives one byte and returns 1 ns after the edge that accepted it
   task automatic send_byte(input logic [7:0] b);
      int   n = 0;
      logic acc;
      bus.in_data  = b;
      bus.in_valid = 1'b1;
      do begin
         @(negedge clk);
         acc = bus.in_ready;
         @(posedge clk);
         #1;
         n++;
      end while (!acc && n < 200);
      if (!acc)
         chk("send_timeout", 0, 1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] l, input bq_t p, input bit bad);
      logic [7:0] s;
      send_byte(8'hA5);
      if (l > 8'd16) begin
         ev_q.push_back({1'b1, 2'b01});
         exp_code = 2'b01;
         send_byte(l);
         @(negedge clk);
         chk("len_err_latency", {30'd0, bus.frame_ok, bus.frame_err}, 32'h1);
         chk("len_err_hunt", {31'd0, bus.busy}, 0);
         return;
      end
      send_byte(l);
      s = l;
      foreach (p[i]) begin
         s = s + p[i];
         send_byte(p[i]);
      end
      if (bad) begin
         ev_q.push_back({1'b1, 2'b10});
         exp_code = 2'b10;
         send_byte(s + 8'd1);
         @(negedge clk);
         chk("csum_err_latency", {30'd0, bus.frame_ok, bus.frame_err}, 32'h1);
         chk("csum_err_no_out", {31'd0, bus.out_valid}, 0);
      end else begin
         ev_q.push_back({1'b0, exp_code});
         foreach (p[i])
            out_q.push_back({(i == p.size() - 1), p[i]});
         send_byte(s);
         @(negedge clk);
         chk("ok_latency", {30'd0, bus.frame_ok, bus.frame_err}, 32'h2);
         chk("out_valid_latency", {31'd0, bus.out_valid}, {31'd0, (l != 8'd0)});
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while ((bus.busy || out_q.size() != 0 || ev_q.size() != 0) && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 1000)
         chk("idle_timeout", 0, 1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      bus.in_data   = 8'd0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_in_ready", {31'd0, bus.in_ready}, 0);
      chk("rst_out", {29'd0, bus.out_valid, bus.out_last, bus.busy}, 0);
      chk("rst_pulses", {30'd0, bus.frame_ok, bus.frame_err}, 0);
      chk("rst_err_code", {30'd0, bus.err_code}, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk("hunt_in_ready", {31'd0, bus.in_ready}, 1);
      @(posedge clk);
      #1;

      // Three-byte frame
      pl = {8'h11, 8'h22, 8'h33};
      send_frame(8'h03, pl, 1'b0);
      wait_idle();
      chk("t1_err_code", {30'd0, bus.err_code}, {30'd0, exp_code});

      // Noise before SYNC, then single-byte frame
      send_byte(8'h00);
      send_byte(8'h5A);
      pl = {8'hFF};
      send_frame(8'h01, pl, 1'b0);
      wait_idle();

      // Bad checksum, then empty frame keeps the sticky code
      pl = {8'h10, 8'h20};
      send_frame(8'h02, pl, 1'b1);
      wait_idle();
      pl = {};
      send_frame(8'h00, pl, 1'b0);
      wait_idle();
      chk("t3_sticky_code", {30'd0, bus.err_code}, 32'h2);

      // Length above MAX_LEN; also boundary LEN == MAX_LEN accepted
      pl = {};
      send_frame(8'h11, pl, 1'b0);
      wait_idle();
      chk("t4_err_code", {30'd0, bus.err_code}, 32'h1);
      pl = {};
      for (int i = 0; i < 16; i++)
         pl.push_back(8'(i * 7 + 3));
      send_frame(8'h10, pl, 1'b0);
      wait_idle();

      // Downstream backpressure during DRAIN
      bus.out_ready = 1'b0;
      pl = {8'hAA, 8'hBB};
      send_frame(8'h02, pl, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {22'd0, bus.out_valid, bus.in_ready, bus.out_last, bus.out_data}, {22'd0, 3'b100, 8'hAA});
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      wait_idle();

      // Reset mid-PAYLOAD aborts without pulses and clears err_code
      send_byte(8'hA5);
      send_byte(8'h03);
      send_byte(8'h11);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", {31'd0, bus.in_ready}, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("mid_rst_state", {27'd0, bus.busy, bus.out_valid, bus.frame_ok, bus.frame_err, 1'b0}, 0);
      chk("mid_rst_code", {30'd0, bus.err_code}, 0);
      exp_code = 2'b00;
      @(posedge clk);
      #1;
      rst = 1'b0;
      pl = {8'h01, 8'h02, 8'h03};
      send_frame(8'h03, pl, 1'b0);
      wait_idle();

`ifdef RX_FRAME_TIMEOUT_EN
      begin
         int n;
         send_byte(8'hA5);
         send_byte(8'h02);
         ev_q.push_back({1'b1, 2'b11});
         exp_code = 2'b11;
         send_byte(8'hAA);
         n = 0;
         @(negedge clk);
         while (!bus.frame_err && n < 300) begin
            n++;
            @(negedge clk);
         end
         chk("timeout_cycles", n, 100);
         wait_idle();
         chk("timeout_code", {30'd0, bus.err_code}, 32'h3);
      end
`endif

      chk("sb_out_empty", out_q.size(), 0);
      chk("sb_ev_empty", ev_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
